noc_credit_rx_port: RTL and testbench
=====================================

Name: noc_credit_rx_port

Overview:
- Receive end of the team's credit-flow-controlled NoC link (enable / 16-bit data / credit).
- Accepts flits from an upstream sender into a local FIFO. Presents them downstream on a valid/ready handshake. Returns one credit pulse per flit drained.
- Tracks packet framing on ingress and counts complete packets.
- Sits at each router input port, opposite the link transmitter. The sender starts with DEPTH credits.

Parameters:
- DEPTH, 4, FIFO depth in flits; power of two, >= 2; equals the sender's initial credit count.
- WIDTH, 16, flit width; bits [WIDTH-1:WIDTH-2] carry the flit type.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_enable  input  1  flit valid from link sender; no backpressure path, sender obeys credits.
- in_data  input  WIDTH  flit from link sender.
- in_credit  output  1  one-cycle credit-return pulse to sender.
- out_valid  output  1  FIFO non-empty.
- out_data  output  WIDTH  FIFO head flit.
- out_ready  input  1  downstream accepts the head flit.
- pkt_count  output  8  complete packets received; wraps 255 -> 0.
- err_overflow  output  1  sticky; a flit arrived while the FIFO was full and could not be stored.
- err_framing  output  1  sticky; an illegal flit-type sequence was seen.

Behaviour:
- Reset (async assert, sync-safe deassert) sets:
  - FIFO empty; out_valid=0; out_data=0.
  - in_credit=0; pkt_count=0; err_overflow=0; err_framing=0; framing FSM=IDLE.
- Reset mid-operation discards stored flits. No credits are returned for them; the sender is reset by the same rst.
- Push: on a posedge with in_enable=1, in_data is written at the tail.
- Pop: on a posedge with out_valid=1 and out_ready=1, the head is removed.
- Latency: a flit pushed at edge N drives out_valid/out_data after edge N, i.e. it is poppable at edge N+1.
- out_data is always the current head. Its value is don't-care (held) when empty.
- Push when full and no pop that cycle: flit dropped, err_overflow set, FIFO unchanged.
- Push when full with a pop that same cycle: flit accepted, occupancy stays DEPTH, no error.
- Push when empty and out_ready=1: no same-cycle bypass; the flit pops at the earliest on the next edge.
- Pointers: log2(DEPTH) bits, wrap naturally. Occupancy counter: log2(DEPTH)+1 bits, range 0..DEPTH.
- Credit return: in_credit is registered. It is high for exactly the one cycle following each pop edge, so back-to-back pops give a continuous high.
- Dropped flits never generate credits.
- Flit types in_data[WIDTH-1:WIDTH-2]: 01=HEAD, 00=BODY, 10=TAIL, 11=SINGLE.
- Framing FSM advances only on in_enable=1, including dropped flits. All flits are stored regardless of framing.
  - IDLE + HEAD -> INPKT.
  - IDLE + SINGLE -> IDLE, pkt_count+1.
  - IDLE + BODY/TAIL -> IDLE, err_framing set.
  - INPKT + BODY -> INPKT.
  - INPKT + TAIL -> IDLE, pkt_count+1.
  - INPKT + HEAD -> INPKT, err_framing set; the new packet starts.
  - INPKT + SINGLE -> IDLE, err_framing set, pkt_count+1.
- err flags clear only on rst.

Test Plan:
- Reset, then idle 10 cycles -> out_valid=0, in_credit=0, pkt_count=0, both err flags 0.
- Single flit 16'hC0DE (SINGLE), out_ready=1 -> out_valid rises the cycle after push, out_data=16'hC0DE, popped next edge, in_credit high exactly 1 cycle after the pop, pkt_count=1.
- DEPTH=4, out_ready=0, push HEAD 16'h4001, BODY 16'h0002, BODY 16'h0003, TAIL 16'h8004 -> FIFO full, no credits. Then out_ready=1 for 4 cycles -> data pops in order, in_credit high 4 consecutive cycles, pkt_count=1.
- FIFO full, out_ready=0, 5th flit 16'h0005 -> dropped, err_overflow=1, no extra credit, the following pops return the original 4 flits only.
- FIFO full, out_ready=1 with a simultaneous push of 16'hC0FF -> accepted, occupancy stays 4, err_overflow=0, 16'hC0FF emerges after the 3 older flits.
- Framing errors: BODY 16'h0011 in IDLE -> err_framing=1, flit still delivered. Separately after reset, HEAD, HEAD, TAIL -> err_framing=1, pkt_count=1. Also drive 256 SINGLE flits -> pkt_count wraps to 0.

Source files
------------

// File: rtl/noc_credit_rx_port_if.sv
// rtl/noc_credit_rx_port_if.sv - link-side and downstream handshake signals of the NoC receive port
interface noc_credit_rx_port_if #(
  parameter int WIDTH = 16
);
  logic             in_enable;
  logic [WIDTH-1:0] in_data;
  logic             in_credit;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // master: the link sender plus the downstream consumer around the port
  modport master (
    output in_enable,
    output in_data,
    input  in_credit,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  // slave: the receive port itself
  modport slave (
    input  in_enable,
    input  in_data,
    output in_credit,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/noc_credit_rx_port.sv
// rtl/noc_credit_rx_port.sv - credit-flow-controlled NoC link receiver with flit FIFO and packet framing checks
module noc_credit_rx_port #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  noc_credit_rx_port_if.slave bus,
  output logic [7:0]          pkt_count,
  output logic                err_overflow,
  output logic                err_framing
);
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

  localparam logic [1:0] C_BODY   = 2'b00;
  localparam logic [1:0] C_HEAD   = 2'b01;
  localparam logic [1:0] C_TAIL   = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_INPKT
  } frame_state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_credit;
  logic [7:0]       r_pkt_count;
  logic             r_err_ovf;
  logic             r_err_frm;
  frame_state_t     r_state;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [1:0]       w_type;

  // A full FIFO can still take a flit when the head leaves on the same edge.
  assign w_full = (r_count == C_FULL);
  assign w_pop  = (r_count != '0) && bus.out_ready;
  assign w_push = bus.in_enable && (!w_full || w_pop);
  assign w_type = bus.in_data[WIDTH-1:WIDTH-2];

  // Flit storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy, credit return and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_credit  <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // One credit per drained flit; dropped flits never earn one.
      r_credit <= w_pop;
      if (bus.in_enable && !w_push) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  // Ingress framing tracker; sees every arriving flit, stored or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pkt_count <= 8'd0;
      r_err_frm   <= 1'b0;
    end else if (bus.in_enable) begin
      case (r_state)
        S_IDLE: begin
          case (w_type)
            C_HEAD: r_state <= S_INPKT;
            C_BODY, C_TAIL: r_err_frm <= 1'b1;
            default: r_pkt_count <= r_pkt_count + 8'd1;
          endcase
        end
        default: begin
          case (w_type)
            C_BODY: r_state <= S_INPKT;
            C_TAIL: begin
              r_state     <= S_IDLE;
              r_pkt_count <= r_pkt_count + 8'd1;
            end
            C_HEAD: r_err_frm <= 1'b1;
            default: begin
              r_state     <= S_IDLE;
              r_err_frm   <= 1'b1;
              r_pkt_count <= r_pkt_count + 8'd1;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.in_credit = r_credit;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign pkt_count     = r_pkt_count;
  assign err_overflow  = r_err_ovf;
  assign err_framing   = r_err_frm;
endmodule

// File: tb/tb_noc_credit_rx_port.sv
// tb/tb_noc_credit_rx_port.sv - self-checking bench for noc_credit_rx_port
module tb_noc_credit_rx_port;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pkt_count;
  logic       err_overflow;
  logic       err_framing;

  int n_checks = 0;
  int n_fail   = 0;

  noc_credit_rx_port_if #(.WIDTH(WIDTH)) bus ();

  noc_credit_rx_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pkt_count    (pkt_count),
    .err_overflow (err_overflow),
    .err_framing  (err_framing)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored flits plus the framing rules.
  logic [15:0] m_q [$];
  logic        m_credit;
  logic [7:0]  m_pkt;
  logic        m_ovf;
  logic        m_frm;
  logic        m_inpkt;
  bit          m_pop;
  bit          m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_credit = 1'b0;
      m_pkt    = 8'd0;
      m_ovf    = 1'b0;
      m_frm    = 1'b0;
      m_inpkt  = 1'b0;
    end else begin
      m_pop    = (m_q.size() > 0) && bus.out_ready;
      m_full   = (m_q.size() == DEPTH);
      m_credit = m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (bus.in_enable) begin
        if (m_full && !m_pop) m_ovf = 1'b1;
        else m_q.push_back(bus.in_data);
        case (bus.in_data[15:14])
          2'b01: begin
            if (m_inpkt) m_frm = 1'b1;
            m_inpkt = 1'b1;
          end
          2'b00: if (!m_inpkt) m_frm = 1'b1;
          2'b10: begin
            if (m_inpkt) m_pkt = m_pkt + 8'd1;
            else m_frm = 1'b1;
            m_inpkt = 1'b0;
          end
          default: begin
            if (m_inpkt) m_frm = 1'b1;
            m_pkt   = m_pkt + 8'd1;
            m_inpkt = 1'b0;
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", bus.out_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("out_data", bus.out_data, m_q[0]);
      check("in_credit", bus.in_credit, m_credit);
      check("pkt_count", pkt_count, m_pkt);
      check("err_overflow", err_overflow, m_ovf);
      check("err_framing", err_framing, m_frm);
    end
  end

  task automatic cyc(input logic en, input logic [15:0] d, input logic rdy);
    bus.in_enable = en;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_enable = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [15:0] pk [4] = '{16'h4001, 16'h0002, 16'h0003, 16'h8004};
  logic [15:0] ex [4] = '{16'h0002, 16'h0003, 16'h8004, 16'hC0FF};

  task automatic fill4();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pk[i], 1'b0);
      check("fill_no_credit", bus.in_credit, 1'b0);
    end
  endtask

  initial begin
    bus.in_enable = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset and idle
    do_reset();
    repeat (10) cyc(1'b0, 16'h0, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 16'h0);
    check("rst_in_credit", bus.in_credit, 1'b0);
    check("rst_pkt_count", pkt_count, 8'd0);
    check("rst_err_ovf", err_overflow, 1'b0);
    check("rst_err_frm", err_framing, 1'b0);

    // Single flit, no bypass, credit one cycle after pop
    cyc(1'b1, 16'hC0DE, 1'b1);
    check("single_valid", bus.out_valid, 1'b1);
    check("single_data", bus.out_data, 16'hC0DE);
    check("single_no_credit", bus.in_credit, 1'b0);
    check("single_pkt", pkt_count, 8'd1);
    cyc(1'b0, 16'h0, 1'b1);
    check("single_popped", bus.out_valid, 1'b0);
    check("single_credit", bus.in_credit, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);
    check("single_credit_end", bus.in_credit, 1'b0);

    // Fill to DEPTH then drain with back-to-back credits
    do_reset();
    fill4();
    check("full_valid", bus.out_valid, 1'b1);
    check("full_pkt", pkt_count, 8'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", bus.out_data, pk[i]);
      cyc(1'b0, 16'h0, 1'b1);
      check("drain_credit", bus.in_credit, 1'b1);
    end
    check("drain_empty", bus.out_valid, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    check("drain_credit_end", bus.in_credit, 1'b0);

    // Overflow drops the fifth flit
    do_reset();
    fill4();
    cyc(1'b1, 16'h0005, 1'b0);
    check("ovf_flag", err_overflow, 1'b1);
    check("ovf_no_credit", bus.in_credit, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_data", bus.out_data, pk[i]);
      cyc(1'b0, 16'h0, 1'b1);
    end
    check("ovf_empty", bus.out_valid, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    check("ovf_credit_end", bus.in_credit, 1'b0);

    // Push into full FIFO with simultaneous pop
    do_reset();
    fill4();
    cyc(1'b1, 16'hC0FF, 1'b1);
    check("pp_no_ovf", err_overflow, 1'b0);
    check("pp_credit", bus.in_credit, 1'b1);
    cyc(1'b1, 16'h0006, 1'b0);
    check("pp_still_full", err_overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("pp_data", bus.out_data, ex[i]);
      cyc(1'b0, 16'h0, 1'b1);
    end
    check("pp_empty", bus.out_valid, 1'b0);

    // Framing: BODY in IDLE still delivered
    do_reset();
    cyc(1'b1, 16'h0011, 1'b1);
    check("frm_body_err", err_framing, 1'b1);
    check("frm_body_data", bus.out_data, 16'h0011);
    cyc(1'b0, 16'h0, 1'b1);
    check("frm_body_credit", bus.in_credit, 1'b1);

    // Framing: HEAD, HEAD, TAIL
    do_reset();
    cyc(1'b1, 16'h4001, 1'b1);
    check("hh_no_err", err_framing, 1'b0);
    cyc(1'b1, 16'h4002, 1'b1);
    check("hh_err", err_framing, 1'b1);
    cyc(1'b1, 16'h8003, 1'b1);
    check("hh_pkt", pkt_count, 8'd1);

    // pkt_count wrap
    do_reset();
    for (int i = 0; i < 255; i++) cyc(1'b1, 16'hC000 | 16'(i), 1'b1);
    check("wrap_255", pkt_count, 8'd255);
    cyc(1'b1, 16'hC0AA, 1'b1);
    check("wrap_0", pkt_count, 8'd0);
    check("wrap_no_frm", err_framing, 1'b0);

    // Randomized traffic against the model, with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cyc($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 55);
    end
    cyc(1'b0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
